button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - Conditions the raw push-button / switch inputs (SELECT, STOP, Set_Impulse, D1..D8) before they reach the chess-clock top level.
// - Per channel: 2-FF synchroniser, counter-based debounce, a debounced level output and a one-cycle press pulse.
// - Optional auto-repeat on held buttons, so the D1..D8 decrement keys step time continuously while held.
// - Sits directly upstream of Top: BTN_LEVEL drives SELECT/STOP; BTN_PULSE drives Set_Impulse and D1..D8.
// PARAMETERS
// - N           11      number of channels. Bit order: [0]=SELECT [1]=STOP [2]=Set_Impulse [3..10]=D1..D8.
// - DEB_CYCLES  250000  consecutive CE cycles a changed input must hold before BTN_LEVEL follows it (>=2).
// - REP_MASK    11'h7F8 per-channel auto-repeat enable; default enables D1..D8 only.
// - REP_DELAY   25000000 CE cycles from debounced press to the first repeat pulse (>=2).
// - REP_PERIOD  5000000 CE cycles between subsequent repeat pulses (>=2).
// PORTS
// - CLK        in   1  system clock; every register uses its rising edge.
// - CLR        in   1  reset, synchronous and active-low: sampled on the CLK rising edge, resets while 0.
// - CE         in   1  clock enable; debounce and repeat counters advance only when CE=1.
// - BTN_IN     in   N  raw asynchronous button levels; active-high.
// - BTN_LEVEL  out  N  debounced level, registered.
// - BTN_PULSE  out  N  one-CLK-cycle pulse on each press and on each auto-repeat, registered.
// BEHAVIOUR
// - Reset (CLR=0 at a rising edge):
//   - Synchroniser FFs, counters and BTN_LEVEL/BTN_PULSE all go to 0; every channel's repeat FSM goes to IDLE.
// - Synchroniser:
//   - Two FFs per channel, clocked every cycle and not gated by CE. This gives 2 cycles of latency; the output is s.
// - Debounce, per channel, counter dcnt of width $clog2(DEB_CYCLES):
//   - While s==BTN_LEVEL: dcnt<=0.
//   - While s!=BTN_LEVEL and CE=1: dcnt increments. When dcnt==DEB_CYCLES-1, BTN_LEVEL<=s and dcnt<=0.
//   - While CE=0, dcnt holds.
//   - A bounce shorter than DEB_CYCLES clears dcnt, so there is no level change.
//   - With CE held at 1, a clean edge on BTN_IN appears on BTN_LEVEL DEB_CYCLES+2 cycles later.
// - Press pulse:
//   - BTN_PULSE[i] goes to 1 on the same edge that BTN_LEVEL[i] goes 0->1, and returns to 0 on the next edge.
//   - A release (1->0) never produces a pulse.
// - Auto-repeat FSM, per channel with REP_MASK[i]=1, counter rcnt:
//   - IDLE: rcnt=0. On a debounced press go to DELAY. (The press pulse comes from the press-pulse logic above.)
//   - DELAY: rcnt increments on CE. When rcnt==REP_DELAY-1, pulse, set rcnt<=0, go to REPEAT.
//   - REPEAT: rcnt increments on CE. When rcnt==REP_PERIOD-1, pulse and set rcnt<=0.
//   - DELAY or REPEAT, BTN_LEVEL falls: go to IDLE and rcnt<=0 on that edge; no pulse.
//   - Channels with REP_MASK[i]=0 stay in IDLE permanently.
// - CE=0: counters and FSMs hold and no new pulse is issued. A pulse already high still clears on the next edge.
// - Channels are fully independent; simultaneous presses on several channels pulse in the same cycle.
// - Reset mid-press with the button held: after CLR returns to 1 the press is treated as new, giving BTN_LEVEL=1 and one pulse after DEB_CYCLES+2 cycles.
// - rcnt is sized $clog2(max(REP_DELAY,REP_PERIOD)). Counters never wrap past their terminal value.
// TESTING (bench: N=11, DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, CE=1 unless stated)
// - Clean press: BTN_IN[1] 0->1 at cycle 0 and held -> BTN_LEVEL[1]=1 from cycle 6; BTN_PULSE[1]=1 at cycle 6 only. SELECT/STOP do not repeat.
// - Bounce: BTN_IN[2] toggles 1,0,1,0 with 1-3 cycle widths, then held 1 -> no pulse during the bounce; exactly one pulse 6 cycles after the final rise.
// - Auto-repeat: BTN_IN[3] held 40 cycles from cycle 0 -> pulses at cycles 6, 16, 19, 22, 25, ...; release -> no further pulse and BTN_LEVEL[3]=0 6 cycles after release.
// - CE gating: CE=1 on alternate cycles, clean press on ch 0 -> BTN_LEVEL[0] rises after 4 CE=1 cycles past the sync stage; the pulse coincides with a CE=1 cycle.
// - Reset mid-repeat: ch 4 in REPEAT, CLR=0 for 2 cycles with the button held -> all outputs 0 during reset; re-press detected 6 cycles after CLR=1, then pulses resume at +10 and every +3.
// - Simultaneous: BTN_IN[10:3]=8'hFF at cycle 0 -> all eight BTN_PULSE bits high together at cycle 6; BTN_PULSE[2:0]=0 throughout.

Source files
------------

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Purpose : groups the button-conditioner data signals so the conditioner and
//           its consumer share one bundle. Clock and reset stay outside.
// Signals :
//   CE        clock enable, driven by the master; counters advance only on CE=1
//   BTN_IN    [N] raw asynchronous button levels (active-high), from the master
//   BTN_LEVEL [N] debounced level, driven by the slave (conditioner)
//   BTN_PULSE [N] one-cycle press / auto-repeat pulse, driven by the slave
// Handshake: there is no valid/ready pair. BTN_PULSE[i]=1 for exactly one
//   CLK cycle is the "event valid" indication and the consumer must accept it
//   on that cycle; CE qualifies time only, never the data.
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N = 11
);
  logic         CE;
  logic [N-1:0] BTN_IN;
  logic [N-1:0] BTN_LEVEL;
  logic [N-1:0] BTN_PULSE;

  modport master (output CE, output BTN_IN, input BTN_LEVEL, input BTN_PULSE);
  modport slave  (input CE, input BTN_IN, output BTN_LEVEL, output BTN_PULSE);
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Purpose : per-channel 2-FF synchroniser, counter debounce, registered
//           debounced level, one-cycle press pulse and optional auto-repeat
//           for the chess-clock push buttons.
// Ports   :
//   CLK  in  system clock, rising edge
//   CLR  in  synchronous active-low reset
//   bus  slave modport of button_conditioner_if (CE, BTN_IN in;
//        BTN_LEVEL, BTN_PULSE out). N must equal the interface's N.
// Channel bit order: [0]=SELECT [1]=STOP [2]=Set_Impulse [3..10]=D1..D8.
// Each channel's repeat FSM state is visible as g_ch[i].state_q.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int           N          = 11,
  parameter int           DEB_CYCLES = 250000,
  parameter logic [N-1:0] REP_MASK   = 11'h7F8,
  parameter int           REP_DELAY  = 25000000,
  parameter int           REP_PERIOD = 5000000
) (
  input  logic                  CLK,
  input  logic                  CLR,
  button_conditioner_if.slave   bus
);

  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY_ST = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

  // Synchroniser runs every cycle; CE does not gate it.
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.BTN_IN;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          lvl_q, lvl_d;
    logic          pulse_q, pulse_d;
    logic          press, release_evt, rep_fire;
    rep_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Debounce: any sample matching the current level restarts the count,
    // so only an uninterrupted run of DEB_CYCLES CE cycles flips the level.
    always_comb begin
      dcnt_d = dcnt_q;
      lvl_d  = lvl_q;
      if (sync2_q[i] == lvl_q) begin
        dcnt_d = '0;
      end else if (bus.CE) begin
        if (dcnt_q == DEB_LAST) begin
          lvl_d  = sync2_q[i];
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    assign press       = ~lvl_q & lvl_d;
    assign release_evt = lvl_q & ~lvl_d;

    // Repeat FSM. A release on the same edge as a terminal count wins, so a
    // release never produces a pulse.
    always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      rep_fire = 1'b0;
      if (REP_MASK[i]) begin
        case (state_q)
          REP_IDLE: begin
            rcnt_d = '0;
            if (press) state_d = REP_DELAY_ST;
          end
          REP_DELAY_ST: begin
            if (release_evt) begin
              state_d = REP_IDLE;
              rcnt_d  = '0;
            end else if (bus.CE) begin
              if (rcnt_q == DLY_LAST) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                state_d  = REP_REPEAT;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end
          REP_REPEAT: begin
            if (release_evt) begin
              state_d = REP_IDLE;
              rcnt_d  = '0;
            end else if (bus.CE) begin
              if (rcnt_q == PER_LAST) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = REP_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    // press and rep_fire can only be true with CE=1, so a CE=0 cycle
    // always clears the pulse.
    assign pulse_d = press | rep_fire;

    always_ff @(posedge CLK) begin
      if (!CLR) begin
        dcnt_q  <= '0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        state_q <= REP_IDLE;
        rcnt_q  <= '0;
      end else begin
        dcnt_q  <= dcnt_d;
        lvl_q   <= lvl_d;
        pulse_q <= pulse_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign bus.BTN_LEVEL[i] = lvl_q;
    assign bus.BTN_PULSE[i] = pulse_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed stimulus for button_conditioner with DEB_CYCLES=4, REP_DELAY=10,
// REP_PERIOD=3. Stimulus is applied 1 time unit after a rising edge; cyc is
// the number of rising edges seen so far. Expected pulses ({cycle, vector})
// and expected level samples go into queues; the monitor samples on the
// falling edge, pops and compares.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  localparam int N = 11;
  localparam int W = 32 + N;

  logic clk = 1'b0;
  logic clr_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] lvl_q[$];

  button_conditioner_if #(.N(N)) bus ();

  button_conditioner #(
    .N(N), .DEB_CYCLES(4), .REP_MASK(11'h7F8), .REP_DELAY(10), .REP_PERIOD(3)
  ) dut (
    .CLK(clk),
    .CLR(clr_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  function automatic void expect_pulse(input int c, input logic [N-1:0] p);
    exp_q.push_back({c, p});
  endfunction

  function automatic void expect_level(input int c, input logic [N-1:0] l);
    lvl_q.push_back({c, l});
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] want;
    logic [W-1:0] got;
    while (lvl_q.size() != 0 && int'(lvl_q[0][W-1:N]) <= cyc) begin
      want = lvl_q.pop_front();
      checks++;
      if (bus.BTN_LEVEL !== want[N-1:0]) begin
        errors++;
        $display("FAIL level cycle %0d: got %h expected %h", cyc, bus.BTN_LEVEL, want[N-1:0]);
      end
    end
    if (bus.BTN_PULSE !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected cycle %0d: got %h expected none", cyc, bus.BTN_PULSE);
      end else begin
        want = exp_q.pop_front();
        got  = {cyc, bus.BTN_PULSE};
        if (got !== want) begin
          errors++;
          $display("FAIL pulse: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.BTN_PULSE, cyc, want[N-1:0], int'(want[W-1:N]));
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pulse_missing: got %0d outstanding, expected 0 (next at cycle %0d)",
                 exp_q.size(), int'(exp_q[0][W-1:N]));
      end
      checks++;
      if (lvl_q.size() != 0) begin
        errors++;
        $display("FAIL level_pending: got %0d outstanding, expected 0", lvl_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int r;
    int u;
    clr_n      = 1'b0;
    bus.CE     = 1'b1;
    bus.BTN_IN = '0;
    tick(1);
    expect_level(1, '0);
    expect_level(2, '0);
    expect_level(3, '0);
    tick(2);
    clr_n = 1'b1;
    tick(2);

    // Clean press on STOP: level and single pulse at +6, no repeat.
    t = cyc;
    bus.BTN_IN[1] = 1'b1;
    expect_level(t + 5, '0);
    expect_level(t + 6, 11'h002);
    expect_pulse(t + 6, 11'h002);
    wait_until(t + 20);
    r = cyc;
    bus.BTN_IN[1] = 1'b0;
    expect_level(r + 5, 11'h002);
    expect_level(r + 6, '0);
    wait_until(r + 10);

    // Bounce on Set_Impulse: widths 2,1,3,1 then held high.
    t = cyc;
    bus.BTN_IN[2] = 1'b1;
    wait_until(t + 2); bus.BTN_IN[2] = 1'b0;
    wait_until(t + 3); bus.BTN_IN[2] = 1'b1;
    wait_until(t + 6); bus.BTN_IN[2] = 1'b0;
    wait_until(t + 7); bus.BTN_IN[2] = 1'b1;
    expect_level(t + 7, '0);
    expect_level(t + 12, '0);
    expect_level(t + 13, 11'h004);
    expect_pulse(t + 13, 11'h004);
    wait_until(t + 22);
    r = cyc;
    bus.BTN_IN[2] = 1'b0;
    expect_level(r + 6, '0);
    wait_until(r + 10);

    // Auto-repeat on D1 held 40 cycles; the release lands on a repeat slot.
    t = cyc;
    bus.BTN_IN[3] = 1'b1;
    expect_level(t + 6, 11'h008);
    expect_pulse(t + 6, 11'h008);
    expect_pulse(t + 16, 11'h008);
    for (int k = 19; k <= 43; k += 3) expect_pulse(t + k, 11'h008);
    expect_level(t + 45, 11'h008);
    expect_level(t + 46, '0);
    wait_until(t + 40);
    bus.BTN_IN[3] = 1'b0;
    wait_until(t + 56);

    // CE on alternate cycles, press on SELECT.
    t = cyc;
    bus.BTN_IN[0] = 1'b1;
    expect_level(t + 8, '0);
    expect_level(t + 9, 11'h001);
    expect_pulse(t + 9, 11'h001);
    for (int k = 0; k < 12; k++) begin
      bus.CE = (k % 2 == 0);
      tick(1);
    end
    bus.CE = 1'b1;
    r = cyc;
    bus.BTN_IN[0] = 1'b0;
    expect_level(r + 6, '0);
    wait_until(r + 10);

    // Reset mid-repeat on D2 with the button held.
    t = cyc;
    bus.BTN_IN[4] = 1'b1;
    expect_pulse(t + 6, 11'h010);
    expect_pulse(t + 16, 11'h010);
    expect_pulse(t + 19, 11'h010);
    expect_pulse(t + 22, 11'h010);
    wait_until(t + 23);
    clr_n = 1'b0;
    expect_level(t + 24, '0);
    expect_level(t + 25, '0);
    wait_until(t + 25);
    clr_n = 1'b1;
    u = cyc;
    expect_level(u + 5, '0);
    expect_level(u + 6, 11'h010);
    expect_pulse(u + 6, 11'h010);
    expect_pulse(u + 16, 11'h010);
    for (int k = 19; k <= 28; k += 3) expect_pulse(u + k, 11'h010);
    expect_level(u + 30, 11'h010);
    expect_level(u + 31, '0);
    wait_until(u + 25);
    bus.BTN_IN[4] = 1'b0;
    wait_until(u + 40);

    // Simultaneous press of D1..D8, released before the first repeat.
    t = cyc;
    bus.BTN_IN[10:3] = 8'hFF;
    expect_level(t + 5, '0);
    expect_level(t + 6, 11'h7F8);
    expect_pulse(t + 6, 11'h7F8);
    wait_until(t + 8);
    bus.BTN_IN = '0;
    expect_level(t + 13, 11'h7F8);
    expect_level(t + 14, '0);
    wait_until(t + 24);

    done = 1'b1;
  end

  // Time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got no completion by %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
